alt_vipvfr131_common_pack_data: RTL and testbench
=================================================

Name: alt_vipvfr131_common_pack_data

Overview:
Write-side counterpart of the frame-buffer unpacker. Packs a stream of narrow pixel words (DATA_WIDTH_IN, e.g. 24-bit RGB) into wide memory words (DATA_WIDTH_OUT, e.g. 128-bit) for the memory-writer master. Packing is a continuous LSB-first bitstream, so pixels may straddle memory words. A flush request pads and emits a trailing partial word at end of frame or line.

Parameters:
DATA_WIDTH_IN, 24, user-side pixel width; must be <= DATA_WIDTH_OUT.
DATA_WIDTH_OUT, 128, memory-side word width.
FILL_WIDTH, clog2(DATA_WIDTH_IN+DATA_WIDTH_OUT), fill-counter width; derived, do not override.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
data_in  input  DATA_WIDTH_IN  pixel from user side
write_in  input  1  data_in valid; accepted when write_in && !stall_in
stall_in  output  1  block cannot accept a pixel this cycle
data_out  output  DATA_WIDTH_OUT  packed memory word
write_out  output  1  data_out valid
stall_out  input  1  memory side cannot take data_out this cycle
flush  input  1  single-cycle pulse: emit residual bits zero-padded
busy  output  1  flush in progress

Behaviour:
- Reset (reset_n low, async): acc=0, fill=0, out_valid/write_out=0, data_out=0, flush_pending/busy=0. Reset mid-word discards partial data; no word is emitted.
- acc: DATA_WIDTH_OUT+DATA_WIDTH_IN-1 bit accumulator. fill: number of valid bits, 0..DATA_WIDTH_OUT+DATA_WIDTH_IN-1.
- Output slot free: slot_free = !out_valid || !stall_out.
- Transfer: if fill >= DATA_WIDTH_OUT and slot_free, then data_out <= acc[OUT-1:0], out_valid <= 1, acc >>= OUT, fill -= OUT.
- Accept: a pixel is written at acc[fill' +: IN], where fill' is fill after any same-cycle transfer; then fill' += IN. Earlier pixels occupy lower bits.
- stall_in = flush_pending || (fill >= OUT && !slot_free). This is combinational from stall_out by design; full throughput is one pixel per clock when the memory side is not stalled.
- Hold: while write_out && stall_out, data_out stays stable. out_valid clears when !stall_out and no new load occurs.
- Latency: the pixel completing a word is accepted in cycle N; write_out asserts in cycle N+1 with that word.
- Flush, two-state FSM:
  - IDLE to FLUSH on flush=1. A pixel accepted in the same cycle is included before the flush.
  - In FLUSH, normal transfers continue while fill >= OUT.
  - When 0 < fill < OUT and slot_free: data_out <= acc[OUT-1:0] with bits >= fill forced to 0, out_valid <= 1, fill <= 0, acc <= 0.
  - FLUSH to IDLE when fill == 0, including an immediate return when flush arrives with fill == 0; no word is emitted in that case.
  - busy = (state == FLUSH).
  - flush while already in FLUSH: ignored.
- Width rule: fill arithmetic is FILL_WIDTH unsigned and never wraps, because stall_in guarantees fill + IN <= OUT + IN - 1 after any transfer.
- Violating DATA_WIDTH_IN > DATA_WIDTH_OUT is an elaboration error (generate-time check).

Decomposition:
- Shared package alt_vipvfr131_common_pkg:
  - clog2 function
  - FLUSH state encoding (IDLE=1'b0, FLUSH=1'b1)
- One natural sub-module: alt_vipvfr131_common_pack_out_reg. It is the single-entry output holding register (data_out, write_out, slot_free, load interface), reusable by other packers.
- Accumulator and FSM stay in the top level.

Test Plan:
- IN=24/OUT=128: 16 pixels, p_k = 24'hA00000|k, no stalls. Expect exactly 3 words. Word0 = {p5[7:0],p4,p3,p2,p1,p0}; last word ends with p15 in bits [127:104]; stall_in never asserted; busy stays 0.
- 6 pixels, then flush pulse. Expect word0 as above, then word1 = {112'h0, p5[23:8]}. busy high for 2 cycles or fewer, then 0. stall_in high while busy.
- Hold stall_out=1 for 10 cycles while streaming. Expect data_out stable with write_out=1. stall_in rises only once fill >= 128 and the slot is occupied. No pixel is lost or duplicated after release (compare against a reference bitstream).
- Flush with fill == 0 (after 16 pixels). Expect no extra word; busy=1 for at most 1 cycle.
- Assert reset_n low mid-word after 3 pixels. Expect write_out, data_out, busy and stall_in all 0 immediately, asynchronously. After release, 16 fresh pixels produce exactly the 3 words of scenario 1.
- Random write_in/stall_out at 50% each over 10k pixels, flush at the end. Expect the concatenated data_out bitstream to equal the concatenated pixels zero-padded to a 128-bit multiple.

Source files
------------

// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared definitions for the vipvfr131 frame-buffer packing blocks.
//   clog2          : ceiling log2, used to size derived counters at elaboration
//   flush_state_e  : two-state flush FSM encoding shared by packers
package alt_vipvfr131_common_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } flush_state_e;

endpackage

// File: rtl/alt_vipvfr131_common_pack_out_reg.sv
// Single-entry output holding register for packers.
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : capture load_data this cycle (only raise when slot_free)
//   load_data      : word to present on data_out
//   stall_out      : downstream cannot take data_out this cycle
//   data_out       : held word, stable while write_out && stall_out
//   write_out      : data_out valid
//   slot_free      : the register can accept a new word this cycle
module alt_vipvfr131_common_pack_out_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall_out,
  output logic [WIDTH-1:0] data_out,
  output logic             write_out,
  output logic             slot_free
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Free when empty, or when the held word leaves at this edge.
  assign slot_free = !valid_q || !stall_out;
  assign data_out  = data_q;
  assign write_out = valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (!stall_out) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_pack_data.sv
// Packs narrow pixel words into wide memory words as a continuous LSB-first
// bitstream; pixels may straddle memory words. A flush pulse emits any residual
// bits as a zero-padded final word.
//   clock, reset_n : clock and asynchronous active-low reset
//   data_in        : pixel from user side
//   write_in       : data_in valid, taken when write_in && !stall_in
//   stall_in       : cannot accept a pixel this cycle
//   data_out       : packed memory word
//   write_out      : data_out valid
//   stall_out      : memory side cannot take data_out this cycle
//   flush          : single-cycle pulse requesting residual emission
//   busy           : flush in progress
module alt_vipvfr131_common_pack_data
  import alt_vipvfr131_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = 24,
  parameter int unsigned DATA_WIDTH_OUT = 128,
  parameter int unsigned FILL_WIDTH     = clog2(DATA_WIDTH_IN + DATA_WIDTH_OUT)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      write_in,
  output logic                      stall_in,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      write_out,
  input  logic                      stall_out,
  input  logic                      flush,
  output logic                      busy
);

  localparam int unsigned ACC_WIDTH = DATA_WIDTH_OUT + DATA_WIDTH_IN - 1;
  localparam logic [FILL_WIDTH-1:0] OUT_F = FILL_WIDTH'(DATA_WIDTH_OUT);
  localparam logic [FILL_WIDTH-1:0] IN_F  = FILL_WIDTH'(DATA_WIDTH_IN);

  if (DATA_WIDTH_IN > DATA_WIDTH_OUT) begin : g_width_check
    $error("DATA_WIDTH_IN must not exceed DATA_WIDTH_OUT");
  end

  flush_state_e              state_q;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d, acc_shift, pixel_ext;
  logic [FILL_WIDTH-1:0]     fill_q, fill_d, fill_shift;
  logic [DATA_WIDTH_OUT-1:0] pad_mask, load_data;
  logic                      xfer, pad, accept, load, slot_free;

  always_comb begin
    xfer     = (fill_q >= OUT_F) && slot_free;
    // Trailing partial word, only while flushing.
    pad      = (state_q == StFlush) && (fill_q != '0) && (fill_q < OUT_F) && slot_free;
    stall_in = (state_q == StFlush) || ((fill_q >= OUT_F) && !slot_free);
    accept   = write_in && !stall_in;

    acc_shift  = acc_q;
    fill_shift = fill_q;
    if (xfer) begin
      acc_shift  = acc_q >> DATA_WIDTH_OUT;
      fill_shift = fill_q - OUT_F;
    end
    // New pixel lands just above the bits surviving this cycle's transfer.
    pixel_ext = ACC_WIDTH'(data_in) << fill_shift;

    pad_mask  = ~({DATA_WIDTH_OUT{1'b1}} << fill_q);
    load      = xfer || pad;
    load_data = pad ? (acc_q[DATA_WIDTH_OUT-1:0] & pad_mask) : acc_q[DATA_WIDTH_OUT-1:0];

    if (pad) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      acc_d  = acc_shift | pixel_ext;
      fill_d = fill_shift + IN_F;
    end else begin
      acc_d  = acc_shift;
      fill_d = fill_shift;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      unique case (state_q)
        // A flush with nothing left after this cycle never enters StFlush.
        StIdle:  if (flush && (fill_d != '0)) state_q <= StFlush;
        StFlush: if (fill_d == '0) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StFlush);

  alt_vipvfr131_common_pack_out_reg #(
    .WIDTH (DATA_WIDTH_OUT)
  ) u_out_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .stall_out (stall_out),
    .data_out  (data_out),
    .write_out (write_out),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_alt_vipvfr131_common_pack_data.sv
module tb_alt_vipvfr131_common_pack_data;

  localparam int IN  = 24;
  localparam int OUT = 128;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [IN-1:0]  data_in = '0;
  logic           write_in = 1'b0;
  logic           stall_out = 1'b0;
  logic           flush = 1'b0;
  logic           stall_in, write_out, busy;
  logic [OUT-1:0] data_out;

  always #5 clock = ~clock;

  alt_vipvfr131_common_pack_data #(
    .DATA_WIDTH_IN  (IN),
    .DATA_WIDTH_OUT (OUT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .write_in  (write_in),
    .stall_in  (stall_in),
    .data_out  (data_out),
    .write_out (write_out),
    .stall_out (stall_out),
    .flush     (flush),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference bitstream model and scoreboard.
  logic [255:0]   m_acc;
  int             m_fill;
  logic [OUT-1:0] exp_q[$];
  logic [OUT-1:0] got[$];
  int             accepted, stall_seen, busy_cycles, busy_nostall;
  logic           prev_hold;
  logic [OUT-1:0] prev_data;
  logic [IN-1:0]  p[16];
  logic [OUT-1:0] w0;

  task automatic check(input string tag, input logic [OUT-1:0] obs, input logic [OUT-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [IN-1:0] px);
    m_acc  = m_acc | (256'(px) << m_fill);
    m_fill = m_fill + IN;
    if (m_fill >= OUT) begin
      exp_q.push_back(m_acc[OUT-1:0]);
      m_acc  = m_acc >> OUT;
      m_fill = m_fill - OUT;
    end
  endtask

  task automatic model_flush();
    if (m_fill > 0) exp_q.push_back(m_acc[OUT-1:0]);
    m_acc  = '0;
    m_fill = 0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc  = '0;
    m_fill = 0;
  endtask

  task automatic clear_stats();
    got.delete();
    stall_seen   = 0;
    busy_cycles  = 0;
    busy_nostall = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [IN-1:0] px);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    write_in = 1'b1;
    data_in  = px;
    while (!ok && n < 1000) begin
      @(negedge clock);
      ok = !stall_in;
      step();
      n++;
    end
    write_in = 1'b0;
    check("send_accept", 128'(ok), 128'(1));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    check(tag, {126'h0, busy, exp_q.size() == 0}, 128'h1);
  endtask

  // Monitor at the inactive edge: scoreboard, hold stability, handshake stats.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (write_out && !stall_out) begin
        check("sb_word", data_out, (exp_q.size() != 0) ? exp_q.pop_front() : 'x);
        got.push_back(data_out);
      end
      if (prev_hold && write_out) check("hold_stable", data_out, prev_data);
      prev_hold = write_out && stall_out;
      prev_data = data_out;
      if (stall_in) stall_seen++;
      if (busy) busy_cycles++;
      if (busy && !stall_in) busy_nostall++;
      if (write_in && !stall_in) begin
        model_push(data_in);
        accepted++;
      end
      if (flush) model_flush();
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) p[k] = 24'hA00000 | 24'(k);
    w0 = {p[5][7:0], p[4], p[3], p[2], p[1], p[0]};
    model_clear();
    clear_stats();
    accepted  = 0;
    prev_hold = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_write_out", 128'(write_out), 128'(0));
    check("rst_data_out", data_out, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_stall_in", 128'(stall_in), 128'(0));
    reset_n = 1'b1;
    step();

    // 16 pixels, no stalls: exactly 3 words
    clear_stats();
    for (int k = 0; k < 16; k++) send(p[k]);
    idle(4);
    check("s1_words", 128'(got.size()), 128'(3));
    check("s1_word0", got[0], w0);
    check("s1_last_top", 128'(got[2][127:104]), 128'(p[15]));
    check("s1_no_stall", 128'(stall_seen), 128'(0));
    check("s1_no_busy", 128'(busy_cycles), 128'(0));

    // Flush with nothing buffered
    clear_stats();
    pulse_flush();
    idle(3);
    check("f0_words", 128'(got.size()), 128'(0));
    check("f0_busy_le1", 128'(busy_cycles <= 1), 128'(1));

    // 6 pixels then flush: padded second word
    clear_stats();
    for (int k = 0; k < 6; k++) send(p[k]);
    pulse_flush();
    wait_drain("s2_drain");
    idle(2);
    check("s2_words", 128'(got.size()), 128'(2));
    check("s2_word0", got[0], w0);
    check("s2_word1", got[1], {112'h0, p[5][23:8]});
    check("s2_busy_len", 128'(busy_cycles >= 1 && busy_cycles <= 2), 128'(1));
    check("s2_stall_while_busy", 128'(busy_nostall), 128'(0));

    // Back-pressure: stream under stall_out for 10 cycles
    clear_stats();
    for (int k = 0; k < 10; k++) send(24'($urandom));
    stall_out = 1'b1;
    write_in  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 24'($urandom);
      step();
    end
    write_in = 1'b0;
    check("s3_write_out_held", 128'(write_out), 128'(1));
    check("s3_stall_in_rose", 128'(stall_seen > 0), 128'(1));
    stall_out = 1'b0;
    for (int k = 0; k < 10; k++) send(24'($urandom));
    pulse_flush();
    wait_drain("s3_drain");

    // Asynchronous reset with a held word and a pending flush
    clear_stats();
    stall_out = 1'b1;
    for (int k = 0; k < 6; k++) send(p[k]);
    pulse_flush();
    check("r_pre_busy", 128'(busy), 128'(1));
    check("r_pre_write_out", 128'(write_out), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("r_write_out", 128'(write_out), 128'(0));
    check("r_data_out", data_out, 128'(0));
    check("r_busy", 128'(busy), 128'(0));
    check("r_stall_in", 128'(stall_in), 128'(0));
    model_clear();
    stall_out = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    clear_stats();
    for (int k = 0; k < 16; k++) send(p[k]);
    idle(4);
    check("r_words", 128'(got.size()), 128'(3));
    check("r_word0", got[0], w0);
    check("r_last_top", 128'(got[2][127:104]), 128'(p[15]));
    check("r_sb_empty", 128'(exp_q.size()), 128'(0));

    // Random handshakes over 10k pixels, then flush
    clear_stats();
    accepted = 0;
    begin
      int n;
      n = 0;
      while (accepted < 10000 && n < 50000) begin
        write_in  = 1'($urandom_range(0, 1));
        data_in   = 24'($urandom);
        stall_out = 1'($urandom_range(0, 1));
        step();
        n++;
      end
    end
    write_in  = 1'b0;
    stall_out = 1'b0;
    check("rand_pixels", 128'(accepted >= 10000), 128'(1));
    pulse_flush();
    wait_drain("rand_drain");
    check("rand_words", 128'(got.size()), 128'((accepted * IN + OUT - 1) / OUT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
